// File: rtl/bus_to_ip_mux_pkg.sv
// Shared types and helpers for the bus_to_ip_mux bridge.
// Slice helper macro selects channel k of a packed per-channel vector.
`ifndef BUS_TO_IP_MUX_SLICE
`define BUS_TO_IP_MUX_SLICE(vec, k, w) vec[(k)*(w) +: (w)]
`endif

package bus_to_ip_mux_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_RD = 3'd1,
        WAIT_RD  = 3'd2,
        DRIVE    = 3'd3,
        DONE     = 3'd4
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) res = i + 1;
        end
        return res;
    endfunction

    // Channel index width, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_to_ip_mux_if.sv
// Strobe-bus and per-channel IP signals of the bus_to_ip_mux bridge.
// BUS_DATA is tri-state and travels as a plain inout port beside this interface.
interface bus_to_ip_mux_if #(
    parameter int unsigned NCH       = 4,
    parameter int unsigned ABUSWIDTH = 16,
    parameter int unsigned DBUSWIDTH = 8
);
    logic                       BUS_RD;
    logic                       BUS_WR;
    logic [ABUSWIDTH-1:0]       BUS_ADD;
    logic                       BUS_ACK;
    logic                       BUS_ERR;
    logic [NCH-1:0]             IP_RD;
    logic [NCH-1:0]             IP_WR;
    logic [NCH*ABUSWIDTH-1:0]   IP_ADD;
    logic [DBUSWIDTH-1:0]       IP_DATA_IN;
    logic [NCH*DBUSWIDTH-1:0]   IP_DATA_OUT;
    logic [NCH-1:0]             IP_ACK;

    // Environment side: bus master plus the IP cluster responses.
    modport master (
        output BUS_RD, BUS_WR, BUS_ADD, IP_DATA_OUT, IP_ACK,
        input  BUS_ACK, BUS_ERR, IP_RD, IP_WR, IP_ADD, IP_DATA_IN
    );

    modport slave (
        input  BUS_RD, BUS_WR, BUS_ADD, IP_DATA_OUT, IP_ACK,
        output BUS_ACK, BUS_ERR, IP_RD, IP_WR, IP_ADD, IP_DATA_IN
    );
endinterface

// File: rtl/bus_to_ip_mux_decode.sv
// Address window decoder: lowest-index window containing addr wins.
// Offset is addr minus that window's base at full address width.
module bus_to_ip_mux_decode
    import bus_to_ip_mux_pkg::*;
#(
    parameter int unsigned NCH       = 4,
    parameter int unsigned ABUSWIDTH = 16,
    parameter logic [NCH*ABUSWIDTH-1:0] BASEADDRS = '0,
    parameter logic [NCH*ABUSWIDTH-1:0] HIGHADDRS = '0
) (
    input  logic [ABUSWIDTH-1:0]          addr,
    output logic [NCH-1:0]                hit,
    output logic [idx_width(NCH)-1:0]     idx,
    output logic [ABUSWIDTH-1:0]          offset,
    output logic                          any
);
    localparam int unsigned IW = idx_width(NCH);

    logic [ABUSWIDTH-1:0] base;
    logic [ABUSWIDTH-1:0] high;
    logic [ABUSWIDTH-1:0] off;

    // base <= addr <= high, evaluated as a wrap-safe offset range test
    always_comb begin
        hit    = '0;
        idx    = '0;
        offset = '0;
        any    = 1'b0;
        base   = '0;
        high   = '0;
        off    = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            base = `BUS_TO_IP_MUX_SLICE(BASEADDRS, k, ABUSWIDTH);
            high = `BUS_TO_IP_MUX_SLICE(HIGHADDRS, k, ABUSWIDTH);
            off  = addr - base;
            if (!any && (high >= base) && (off <= (high - base))) begin
                any    = 1'b1;
                hit[k] = 1'b1;
                idx    = IW'(k);
                offset = off;
            end
        end
    end
endmodule

// File: rtl/bus_to_ip_mux.sv
// Registered bridge from one strobe bus to NCH base-relative IP windows.
// Define BUS_TO_IP_MUX_TIMEOUT_EN to bound read wait states by TIMEOUT cycles.
module bus_to_ip_mux
    import bus_to_ip_mux_pkg::*;
#(
    parameter int unsigned NCH       = 4,
    parameter int unsigned ABUSWIDTH = 16,
    parameter int unsigned DBUSWIDTH = 8,
    parameter logic [NCH*ABUSWIDTH-1:0] BASEADDRS = '0,
    parameter logic [NCH*ABUSWIDTH-1:0] HIGHADDRS = '0,
    parameter logic [DBUSWIDTH-1:0]     ERR_DATA  = '1
`ifdef BUS_TO_IP_MUX_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 15
`endif
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST_N,
    inout  wire [DBUSWIDTH-1:0]  BUS_DATA,
    bus_to_ip_mux_if.slave       bus
);
    localparam int unsigned IW = idx_width(NCH);

    state_t                   state;
    logic [IW-1:0]            sel;
    logic [DBUSWIDTH-1:0]     rd_data;
    logic                     drive;

    logic [NCH-1:0]           dec_hit;
    logic [IW-1:0]            dec_idx;
    logic [ABUSWIDTH-1:0]     dec_offset;
    logic                     dec_any;
    logic [NCH*ABUSWIDTH-1:0] add_placed;
    logic [DBUSWIDTH-1:0]     ip_rdata;
    logic                     ack_sel;

`ifdef BUS_TO_IP_MUX_TIMEOUT_EN
    localparam int unsigned CW = clog2(TIMEOUT + 1);
    logic [CW-1:0]            cnt;
`endif

    bus_to_ip_mux_decode #(
        .NCH       (NCH),
        .ABUSWIDTH (ABUSWIDTH),
        .BASEADDRS (BASEADDRS),
        .HIGHADDRS (HIGHADDRS)
    ) u_decode (
        .addr   (bus.BUS_ADD),
        .hit    (dec_hit),
        .idx    (dec_idx),
        .offset (dec_offset),
        .any    (dec_any)
    );

    // Offset lands in the selected channel's slice; other channels see zero.
    always_comb begin
        add_placed = '0;
        `BUS_TO_IP_MUX_SLICE(add_placed, 32'(dec_idx), ABUSWIDTH) = dec_offset;
    end

    assign ip_rdata = `BUS_TO_IP_MUX_SLICE(bus.IP_DATA_OUT, 32'(sel), DBUSWIDTH);
    assign ack_sel  = bus.IP_ACK[sel];
    assign BUS_DATA = drive ? rd_data : 'z;

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state          <= IDLE;
            sel            <= '0;
            rd_data        <= '0;
            drive          <= 1'b0;
            bus.BUS_ACK    <= 1'b0;
            bus.BUS_ERR    <= 1'b0;
            bus.IP_RD      <= '0;
            bus.IP_WR      <= '0;
            bus.IP_ADD     <= '0;
            bus.IP_DATA_IN <= '0;
`ifdef BUS_TO_IP_MUX_TIMEOUT_EN
            cnt            <= '0;
`endif
        end else begin
            // Strobes and the ack pulse are single-cycle unless re-asserted below.
            bus.BUS_ACK <= 1'b0;
            bus.BUS_ERR <= 1'b0;
            bus.IP_RD   <= '0;
            bus.IP_WR   <= '0;
            drive       <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.BUS_RD && bus.BUS_WR) begin
                        state       <= DONE;
                        bus.BUS_ACK <= 1'b1;
                        bus.BUS_ERR <= 1'b1;
                    end else if (bus.BUS_WR) begin
                        state       <= DONE;
                        bus.BUS_ACK <= 1'b1;
                        if (dec_any) begin
                            bus.IP_WR      <= dec_hit;
                            bus.IP_ADD     <= add_placed;
                            bus.IP_DATA_IN <= BUS_DATA;
                        end else begin
                            bus.BUS_ERR <= 1'b1;
                        end
                    end else if (bus.BUS_RD) begin
                        if (dec_any) begin
                            state      <= ISSUE_RD;
                            sel        <= dec_idx;
                            bus.IP_RD  <= dec_hit;
                            bus.IP_ADD <= add_placed;
`ifdef BUS_TO_IP_MUX_TIMEOUT_EN
                            cnt        <= CW'(1);
`endif
                        end else begin
                            state       <= DRIVE;
                            rd_data     <= ERR_DATA;
                            drive       <= 1'b1;
                            bus.BUS_ACK <= 1'b1;
                            bus.BUS_ERR <= 1'b1;
                        end
                    end
                end
                ISSUE_RD, WAIT_RD: begin
                    if (ack_sel) begin
                        state       <= DRIVE;
                        rd_data     <= ip_rdata;
                        drive       <= 1'b1;
                        bus.BUS_ACK <= 1'b1;
`ifdef BUS_TO_IP_MUX_TIMEOUT_EN
                    end else if (cnt == CW'(TIMEOUT)) begin
                        state       <= DRIVE;
                        rd_data     <= ERR_DATA;
                        drive       <= 1'b1;
                        bus.BUS_ACK <= 1'b1;
                        bus.BUS_ERR <= 1'b1;
                    end else begin
                        state <= WAIT_RD;
                        cnt   <= cnt + CW'(1);
                    end
`else
                    end else begin
                        state <= WAIT_RD;
                    end
`endif
                end
                DRIVE, DONE: begin
                    state      <= IDLE;
                    bus.IP_ADD <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_to_ip_mux.sv
// Scoreboard bench for bus_to_ip_mux: two windows at 0x0000-0x00FF and 0x0100-0x01FF.
// Timeout cases run only when BUS_TO_IP_MUX_TIMEOUT_EN is defined.
module tb_bus_to_ip_mux;

    typedef struct {
        int          t0;
        int          lat;
        logic        err;
        int          dmode;   // 0: bus released, 1: data expected, 2: don't care
        logic [7:0]  data;
        logic [1:0]  ip_wr;
        logic [31:0] ip_add;
        bit          chk_din;
        logic [7:0]  din;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    wire  [7:0] bus_data;
    logic       tb_drv;
    logic [7:0] tb_val;
    assign bus_data = tb_drv ? tb_val : 'z;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_to_ip_mux_if #(.NCH(2), .ABUSWIDTH(16), .DBUSWIDTH(8)) bus ();

    bus_to_ip_mux #(
        .NCH       (2),
        .ABUSWIDTH (16),
        .DBUSWIDTH (8),
        .BASEADDRS (32'h0100_0000),
        .HIGHADDRS (32'h01FF_00FF),
        .ERR_DATA  (8'hFF)
    ) dut (
        .BUS_CLK   (clk),
        .BUS_RST_N (rst_n),
        .BUS_DATA  (bus_data),
        .bus       (bus)
    );

    function automatic void check(input string name, input logic ok,
                                  input logic [63:0] act, input logic [63:0] req);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Released bus reads as Z in 4-state simulators and as 0 in 2-state ones.
    function automatic logic released();
        return (bus_data === 8'hzz) || (bus_data === 8'h00);
    endfunction

    function automatic exp_t mk(input int lat, input logic err, input int dmode,
                                input logic [7:0] data, input logic [1:0] ip_wr,
                                input logic [31:0] ip_add, input bit chk_din,
                                input logic [7:0] din);
        exp_t e;
        e.t0 = 0; e.lat = lat; e.err = err; e.dmode = dmode; e.data = data;
        e.ip_wr = ip_wr; e.ip_add = ip_add; e.chk_din = chk_din; e.din = din;
        return e;
    endfunction

    // Monitor: every BUS_ACK pops one expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && bus.BUS_ACK === 1'b1) begin
            check("ack_expected", sb.size() != 0, 64'(sb.size()), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("ack_latency", (cyc - e.t0) == e.lat, 64'(cyc - e.t0), 64'(e.lat));
                check("bus_err", bus.BUS_ERR === e.err, 64'(bus.BUS_ERR), 64'(e.err));
                if (e.dmode == 1)
                    check("bus_data", bus_data === e.data, 64'(bus_data), 64'(e.data));
                else if (e.dmode == 0)
                    check("bus_data_released", released(), 64'(bus_data), 64'h0);
                check("ip_wr", bus.IP_WR === e.ip_wr, 64'(bus.IP_WR), 64'(e.ip_wr));
                check("ip_add", bus.IP_ADD === e.ip_add, 64'(bus.IP_ADD), 64'(e.ip_add));
                if (e.chk_din)
                    check("ip_data_in", bus.IP_DATA_IN === e.din, 64'(bus.IP_DATA_IN), 64'(e.din));
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_ack"},    bus.BUS_ACK === 1'b0,    64'(bus.BUS_ACK), 64'h0);
        check({tag, "_err"},    bus.BUS_ERR === 1'b0,    64'(bus.BUS_ERR), 64'h0);
        check({tag, "_ip_rd"},  bus.IP_RD === 2'b00,     64'(bus.IP_RD), 64'h0);
        check({tag, "_ip_wr"},  bus.IP_WR === 2'b00,     64'(bus.IP_WR), 64'h0);
        check({tag, "_ip_add"}, bus.IP_ADD === 32'h0,    64'(bus.IP_ADD), 64'h0);
        check({tag, "_ip_din"}, bus.IP_DATA_IN === 8'h0, 64'(bus.IP_DATA_IN), 64'h0);
        check({tag, "_bus_z"},  released(),              64'(bus_data), 64'h0);
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] data,
                            input logic both, input exp_t e_in);
        exp_t e;
        e = e_in;
        @(negedge clk);
        bus.BUS_WR = 1'b1; bus.BUS_RD = both; bus.BUS_ADD = addr;
        tb_drv = 1'b1; tb_val = data;
        e.t0 = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1 bus.BUS_WR = 1'b0; bus.BUS_RD = 1'b0; tb_drv = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("wr_no_ip_rd", bus.IP_RD === 2'b00, 64'(bus.IP_RD), 64'h0);
            if (c != 1) begin
                check("ip_wr_pulse", bus.IP_WR === 2'b00, 64'(bus.IP_WR), 64'h0);
                check("wr_bus_z", released(), 64'(bus_data), 64'h0);
            end
        end
    endtask

    // delay: cycles after IP_RD until IP_ACK (-1 = never); noise_c: cycle of an
    // ack on the other channel; extra_c: cycle of a stray BUS_RD (0 = none).
    task automatic do_read(input logic [15:0] addr, input int ch, input int delay,
                           input logic [7:0] data, input int noise_c, input int extra_c,
                           input logic [1:0] exp_rd, input exp_t e_in);
        exp_t        e;
        logic [1:0]  ack;
        logic [15:0] dout;
        e = e_in;
        @(negedge clk);
        bus.BUS_RD = 1'b1; bus.BUS_ADD = addr;
        e.t0 = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1 bus.BUS_RD = 1'b0;
        for (int c = 1; c <= e.lat + 2; c++) begin
            @(negedge clk);
            ack  = 2'b00;
            dout = 16'h1111;
            if (c == 1 + delay) begin
                ack[ch] = 1'b1;
                dout[ch*8 +: 8] = data;
            end
            if (c == noise_c) ack[1-ch] = 1'b1;
            bus.IP_ACK = ack;
            bus.IP_DATA_OUT = dout;
            bus.BUS_RD = (c == extra_c);
            check("ip_rd", bus.IP_RD === ((c == 1) ? exp_rd : 2'b00), 64'(bus.IP_RD),
                  64'((c == 1) ? exp_rd : 2'b00));
            if (c <= e.lat)
                check("ip_add_hold", bus.IP_ADD === e.ip_add, 64'(bus.IP_ADD), 64'(e.ip_add));
            else
                check("ip_add_idle", bus.IP_ADD === 32'h0, 64'(bus.IP_ADD), 64'h0);
            if (c != e.lat)
                check("rd_bus_z", released(), 64'(bus_data), 64'h0);
        end
        bus.IP_ACK = 2'b00;
        bus.BUS_RD = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        tb_drv = 1'b0; tb_val = 8'h00;
        bus.BUS_RD = 1'b0; bus.BUS_WR = 1'b0; bus.BUS_ADD = 16'h0;
        bus.IP_ACK = 2'b00; bus.IP_DATA_OUT = 16'h0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        do_write(16'h0105, 8'hA5, 1'b0, mk(1, 1'b0, 0, 8'h00, 2'b10, 32'h0005_0000, 1'b1, 8'hA5));
        do_read (16'h0010, 0, 0, 8'h3C, 0, 0, 2'b01, mk(2, 1'b0, 1, 8'h3C, 2'b00, 32'h0000_0010, 1'b0, 8'h0));
        do_read (16'h0120, 1, 5, 8'h96, 2, 3, 2'b10, mk(7, 1'b0, 1, 8'h96, 2'b00, 32'h0020_0000, 1'b0, 8'h0));
        do_read (16'h0300, 0, -1, 8'h00, 0, 0, 2'b00, mk(1, 1'b1, 1, 8'hFF, 2'b00, 32'h0, 1'b0, 8'h0));
        do_write(16'h0200, 8'h77, 1'b0, mk(1, 1'b1, 0, 8'h00, 2'b00, 32'h0, 1'b0, 8'h0));
        do_write(16'h0010, 8'h44, 1'b1, mk(1, 1'b1, 2, 8'h00, 2'b00, 32'h0, 1'b0, 8'h0));
        do_write(16'h00FF, 8'h5A, 1'b0, mk(1, 1'b0, 0, 8'h00, 2'b01, 32'h0000_00FF, 1'b1, 8'h5A));
        do_write(16'h01FF, 8'hC3, 1'b0, mk(1, 1'b0, 0, 8'h00, 2'b10, 32'h00FF_0000, 1'b1, 8'hC3));
        do_read (16'h0100, 1, 2, 8'h81, 0, 0, 2'b10, mk(4, 1'b0, 1, 8'h81, 2'b00, 32'h0000_0000, 1'b0, 8'h0));

`ifdef BUS_TO_IP_MUX_TIMEOUT_EN
        do_read (16'h0120, 1, -1, 8'h00, 0, 0, 2'b10, mk(16, 1'b1, 1, 8'hFF, 2'b00, 32'h0020_0000, 1'b0, 8'h0));
        do_read (16'h0120, 1, 14, 8'h69, 0, 0, 2'b10, mk(16, 1'b0, 1, 8'h69, 2'b00, 32'h0020_0000, 1'b0, 8'h0));
`endif

        // Reset while waiting for IP_ACK aborts the read without a replay.
        @(negedge clk);
        bus.BUS_RD = 1'b1; bus.BUS_ADD = 16'h0120;
        @(posedge clk);
        #1 bus.BUS_RD = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_pre_ip_add", bus.IP_ADD === 32'h0020_0000, 64'(bus.IP_ADD), 64'h0020_0000);
        rst_n = 1'b0;
        #1;
        check_idle("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("abort_no_replay", bus.IP_RD === 2'b00, 64'(bus.IP_RD), 64'h0);
        end
        do_read (16'h0010, 0, 1, 8'h5C, 0, 0, 2'b01, mk(3, 1'b0, 1, 8'h5C, 2'b00, 32'h0000_0010, 1'b0, 8'h0));

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size() == 0, 64'(sb.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
